// File: rtl/epp_pkg.sv
// Shared encodings for the EPP host master: command types, FSM states and
// the pin levels that mean "bus idle".
package epp_pkg;

    typedef enum logic [1:0] {
        CMD_AWR = 2'b00,
        CMD_ARD = 2'b01,
        CMD_DWR = 2'b10,
        CMD_DRD = 2'b11
    } cmd_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TURN,
        ST_SETUP,
        ST_STROBE,
        ST_RELEASE,
        ST_HOLD,
        ST_DONE
    } state_e;

    localparam logic STB_IDLE = 1'b1;
    localparam logic WR_IDLE  = 1'b1;
    localparam logic WR_WRITE = 1'b0;

    function automatic logic is_read(input cmd_type_e t);
        return (t == CMD_ARD) || (t == CMD_DRD);
    endfunction

    function automatic logic is_data(input cmd_type_e t);
        return (t == CMD_DWR) || (t == CMD_DRD);
    endfunction

endpackage

// File: rtl/epp_host_master_if.sv
// Command/response handshake between a command source (master side) and
// the EPP host master block (slave side).
interface epp_host_master_if;
    import epp_pkg::*;

    logic      cmd_valid;
    logic      cmd_ready;
    cmd_type_e cmd_type;
    logic [7:0] cmd_wdata;
    logic      rsp_valid;
    logic [7:0] rsp_rdata;
    logic      rsp_err;

    modport master (
        output cmd_valid, cmd_type, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level (EppWait).
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/epp_host_master.sv
// EPP host (initiator): turns one accepted command into a full address/data
// strobe handshake with an EPP peripheral, with per-edge timeout.
module epp_host_master
    import epp_pkg::*;
#(
    parameter int SETUP_CYC   = 2,
    parameter int TIMEOUT_CYC = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    epp_host_master_if.slave cmd,
    output logic             EppAstb,
    output logic             EppDstb,
    output logic             EppWr,
    input  logic             EppWait,
    inout  wire  [7:0]       DB
);

    localparam int SW = $clog2(SETUP_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SW-1:0] SETUP_LAST   = SW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

    state_e          state_reg, state_next;
    cmd_type_e       type_reg, type_next;
    logic [7:0]      wdata_reg, wdata_next;
    logic [7:0]      rdata_reg, rdata_next;
    logic [7:0]      db_out_reg, db_out_next;
    logic            db_oe_reg, db_oe_next;
    logic            astb_reg, astb_next;
    logic            dstb_reg, dstb_next;
    logic            wr_reg, wr_next;
    logic            err_reg, err_next;
    logic [SW-1:0]   setup_cnt_reg, setup_cnt_next;
    logic [TW-1:0]   to_cnt_reg, to_cnt_next;
    logic            wait_s;
    logic            to_hit;
    logic [7:0]      db_in;

    sync_ff #(.STAGES(SYNC_STAGES)) u_wait_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (EppWait),
        .q     (wait_s)
    );

    // The peripheral owns DB whenever EppWr is high, so the enable is only
    // raised strictly inside the EppWr-low window.
    assign DB    = db_oe_reg ? db_out_reg : 8'hzz;
    assign db_in = DB;

    assign EppAstb = astb_reg;
    assign EppDstb = dstb_reg;
    assign EppWr   = wr_reg;

    assign cmd.cmd_ready = (state_reg == ST_IDLE);
    assign cmd.rsp_valid = (state_reg == ST_DONE);
    assign cmd.rsp_err   = (state_reg == ST_DONE) && err_reg;
    assign cmd.rsp_rdata = rdata_reg;

    assign to_hit = (to_cnt_reg == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            type_reg      <= CMD_AWR;
            wdata_reg     <= '0;
            rdata_reg     <= '0;
            db_out_reg    <= '0;
            db_oe_reg     <= 1'b0;
            astb_reg      <= STB_IDLE;
            dstb_reg      <= STB_IDLE;
            wr_reg        <= WR_IDLE;
            err_reg       <= 1'b0;
            setup_cnt_reg <= '0;
            to_cnt_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            type_reg      <= type_next;
            wdata_reg     <= wdata_next;
            rdata_reg     <= rdata_next;
            db_out_reg    <= db_out_next;
            db_oe_reg     <= db_oe_next;
            astb_reg      <= astb_next;
            dstb_reg      <= dstb_next;
            wr_reg        <= wr_next;
            err_reg       <= err_next;
            setup_cnt_reg <= setup_cnt_next;
            to_cnt_reg    <= to_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        type_next      = type_reg;
        wdata_next     = wdata_reg;
        rdata_next     = rdata_reg;
        db_out_next    = db_out_reg;
        db_oe_next     = db_oe_reg;
        astb_next      = astb_reg;
        dstb_next      = dstb_reg;
        wr_next        = wr_reg;
        err_next       = err_reg;
        setup_cnt_next = setup_cnt_reg;
        to_cnt_next    = to_cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    type_next  = cmd.cmd_type;
                    wdata_next = cmd.cmd_wdata;
                    wr_next    = is_read(cmd.cmd_type) ? WR_IDLE : WR_WRITE;
                    err_next   = 1'b0;
                    state_next = ST_TURN;
                end
            end

            ST_TURN: begin
                if (!is_read(type_reg)) begin
                    db_oe_next  = 1'b1;
                    db_out_next = wdata_reg;
                end
                setup_cnt_next = '0;
                state_next     = ST_SETUP;
            end

            // A strobe must never fall while the peripheral still acknowledges
            // a previous (possibly reset-aborted) cycle.
            ST_SETUP: begin
                if (setup_cnt_reg != SETUP_LAST) begin
                    setup_cnt_next = setup_cnt_reg + 1'b1;
                end else if (!wait_s) begin
                    to_cnt_next = '0;
                    if (is_data(type_reg)) begin
                        dstb_next = 1'b0;
                    end else begin
                        astb_next = 1'b0;
                    end
                    state_next = ST_STROBE;
                end
            end

            ST_STROBE: begin
                if (wait_s) begin
                    if (is_read(type_reg)) begin
                        rdata_next = db_in;
                    end
                    astb_next   = STB_IDLE;
                    dstb_next   = STB_IDLE;
                    to_cnt_next = '0;
                    state_next  = ST_RELEASE;
                end else if (to_hit) begin
                    err_next   = 1'b1;
                    astb_next  = STB_IDLE;
                    dstb_next  = STB_IDLE;
                    state_next = ST_HOLD;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end

            ST_RELEASE: begin
                if (!wait_s) begin
                    state_next = ST_HOLD;
                end else if (to_hit) begin
                    err_next   = 1'b1;
                    state_next = ST_HOLD;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end

            ST_HOLD: begin
                db_oe_next = 1'b0;
                state_next = ST_DONE;
            end

            ST_DONE: begin
                wr_next    = WR_IDLE;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
